// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Holds the downstream clock domain in reset until the PLL has reported lock
//   continuously for STABLE_CYCLES cycles, then keeps the reset asserted for a
//   further HOLD_CYCLES cycles before releasing it. Lock loss while running
//   re-enters the sequence and is counted; software can request a re-reset.
//
// Ports
//   clock      in   PLL output clock of the consuming domain (sole clock)
//   resetn     in   synchronous active-low reset
//   locked     in   PLL lock indicator, asynchronous to clock
//   sw_reset   in   single-cycle software re-reset request (honoured in RUN)
//   rst_out_n  out  registered active-low reset for the clock domain
//   ready      out  registered, high only in RUN
//   state      out  FSM state: 0 WAIT_LOCK, 1 STABILIZE, 2 HOLD, 3 RUN
//   loss_count out  saturating count of lock losses seen in RUN

module pll_reset_sequencer #(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES   = 16
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       locked,
    input  logic       sw_reset,
    output logic       rst_out_n,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] loss_count
);

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] STABILIZE = 2'd1;
    localparam logic [1:0] HOLD      = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);

    logic [1:0]  sync_q;
    logic        locked_s;
    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  loss_q, loss_d;
    logic        rst_out_n_q;
    logic        ready_q;

    assign locked_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = STABILIZE;
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RUN: begin
                cnt_d = '0;
                // Lock loss outranks a simultaneous software request.
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end else if (sw_reset) begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync_q      <= '0;
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            loss_q      <= '0;
            rst_out_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], locked};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            // Decoded from the next state so the outputs move on the same
            // edge as state, without a combinational path to the pins.
            rst_out_n_q <= (state_d == RUN);
            ready_q     <= (state_d == RUN);
        end
    end

    assign rst_out_n  = rst_out_n_q;
    assign ready      = ready_q;
    assign state      = state_q;
    assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Directed bench for pll_reset_sequencer with STABLE_CYCLES=4, HOLD_CYCLES=3.
//   Inputs change 1 time unit after a rising edge; outputs are checked at the
//   same point, so each tick() corresponds to one observed clock edge.

module tb_pll_reset_sequencer;

    logic       clock;
    logic       resetn;
    logic       locked;
    logic       sw_reset;
    logic       rst_out_n;
    logic       ready;
    logic [1:0] state;
    logic [7:0] loss_count;

    int n_checks = 0;
    int n_fail   = 0;

    pll_reset_sequencer #(
        .STABLE_CYCLES(4),
        .HOLD_CYCLES  (3)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .locked    (locked),
        .sw_reset  (sw_reset),
        .rst_out_n (rst_out_n),
        .ready     (ready),
        .state     (state),
        .loss_count(loss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int st, input int rn,
                             input int rdy, input int loss);
        check({tag, ".state"},     int'(state),      st);
        check({tag, ".rst_out_n"}, int'(rst_out_n),  rn);
        check({tag, ".ready"},     int'(ready),      rdy);
        check({tag, ".loss"},      int'(loss_count), loss);
    endtask

    initial begin
        resetn   = 1'b0;
        locked   = 1'b0;
        sw_reset = 1'b0;
        tick(3);
        check_all("reset", 0, 0, 0, 0);

        // Release reset with lock already high; E0 is the first edge after.
        resetn = 1'b1;
        locked = 1'b1;
        tick(1);  // E0
        check("e0.state", int'(state), 0);
        tick(1);  // E1
        check("e1.state", int'(state), 0);
        tick(1);  // E2
        check("e2.state", int'(state), 1);

        // One-cycle glitch sampled at E3; FSM sees it at E5.
        locked = 1'b0;
        tick(1);  // E3
        locked = 1'b1;
        check("glitch.e3", int'(state), 1);
        tick(1);  // E4
        check("glitch.e4", int'(state), 1);
        tick(1);  // E5
        check_all("glitch.e5", 0, 0, 0, 0);
        // Relock sampled from E4: STABILIZE at E6, HOLD at E10, RUN at E13.
        tick(1);  // E6
        check("relock.e6", int'(state), 1);
        tick(3);  // E9
        check("relock.e9", int'(state), 1);
        tick(1);  // E10
        check_all("relock.e10", 2, 0, 0, 0);
        tick(2);  // E12
        check_all("relock.e12", 2, 0, 0, 0);
        tick(1);  // E13
        check_all("relock.e13", 3, 1, 1, 0);

        // Software re-reset from RUN.
        sw_reset = 1'b1;
        tick(1);
        sw_reset = 1'b0;
        check_all("swr.enter", 2, 0, 0, 0);
        sw_reset = 1'b1;   // ignored in HOLD
        tick(1);
        sw_reset = 1'b0;
        check_all("swr.hold1", 2, 0, 0, 0);
        tick(1);
        check("swr.hold2", int'(state), 2);
        tick(1);
        check_all("swr.run", 3, 1, 1, 0);

        // Lock loss in RUN.
        locked = 1'b0;
        tick(1);
        check_all("loss.a0", 3, 1, 1, 0);
        tick(1);
        check_all("loss.a1", 3, 1, 1, 0);
        tick(1);
        check_all("loss.a2", 0, 0, 0, 1);
        locked = 1'b1;
        tick(9);
        check_all("loss.relock8", 2, 0, 0, 1);
        tick(1);
        check_all("loss.relock9", 3, 1, 1, 1);

        // Lock loss and sw_reset seen by the FSM in the same cycle.
        locked = 1'b0;
        tick(2);
        sw_reset = 1'b1;
        tick(1);
        sw_reset = 1'b0;
        check_all("simul", 0, 0, 0, 2);

        // Drive the loss counter to saturation (260 loss events in total).
        for (int i = 2; i < 260; i++) begin
            locked = 1'b1;
            tick(10);
            locked = 1'b0;
            tick(3);
            if (i == 254) check("sat.at255", int'(loss_count), 255);
        end
        check_all("sat.final", 0, 0, 0, 255);

        // Reset asserted mid-HOLD clears everything including loss_count.
        locked = 1'b1;
        tick(7);
        check_all("midhold", 2, 0, 0, 255);
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        check_all("midhold.reset", 0, 0, 0, 0);
        tick(2);
        check("post_reset.e1", int'(state), 0);
        tick(1);
        check("post_reset.e2", int'(state), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
